// File: rtl/attn_pkg.sv
// attn_pkg: shared defaults, derived widths and FSM encoding for the attention sink blocks
package attn_pkg;
  localparam int DATA_WIDTH   = 16;
  localparam int TOKEN_DIM    = 4;
  localparam int TOKEN_NUM    = 8;
  localparam int PIPE_LATENCY = 4;
  localparam int TOKEN_BITS   = DATA_WIDTH * TOKEN_DIM;
  localparam int MAT_BITS     = TOKEN_BITS * TOKEN_NUM;
  localparam int IDX_W        = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/attn_launch_delay.sv
// attn_launch_delay: DEPTH-stage shift register marking when a valid-less pipeline's result is present
module attn_launch_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/attn_out_streamer.sv
// attn_out_streamer: captures the attention output matrix on its result cycle and streams it token by token
module attn_out_streamer #(
  parameter int DATA_WIDTH   = attn_pkg::DATA_WIDTH,
  parameter int TOKEN_DIM    = attn_pkg::TOKEN_DIM,
  parameter int TOKEN_NUM    = attn_pkg::TOKEN_NUM,
  parameter int PIPE_LATENCY = attn_pkg::PIPE_LATENCY,
  localparam int TW = DATA_WIDTH * TOKEN_DIM,
  localparam int MW = TW * TOKEN_NUM,
  localparam int IW = attn_pkg::idx_w(TOKEN_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          launch,
  input  logic [MW-1:0] mat_in,
  output logic          tok_valid,
  input  logic          tok_ready,
  output logic [TW-1:0] tok_data,
  output logic [IW-1:0] tok_idx,
  output logic          tok_last,
  output logic          busy,
  output logic          overflow,
  input  logic          clr_overflow
);
  import attn_pkg::*;
  state_t state, state_n;
  logic [MW-1:0] mat_q;
  logic cap, beat, load, drop;
  attn_launch_delay #(.DEPTH(PIPE_LATENCY)) u_dly (.clk(clk), .rst(rst), .din(launch), .dout(cap));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // a capture on the final beat reloads in place so back-to-back matrices have no bubble
  always_comb begin
    tok_valid = state == STREAM;
    busy      = tok_valid;
    tok_last  = tok_valid && tok_idx == IW'(TOKEN_NUM - 1);
    beat      = tok_valid && tok_ready;
    load      = cap && (!tok_valid || (beat && tok_last));
    drop      = cap && tok_valid && !(beat && tok_last);
    state_n   = load ? STREAM : (beat && tok_last) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mat_q    <= '0;
      tok_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        mat_q   <= mat_in;
        tok_idx <= '0;
      end else if (beat && !tok_last) tok_idx <= tok_idx + 1'b1;
      overflow <= drop || (overflow && !clr_overflow);
    end
  assign tok_data = mat_q[tok_idx * TW +: TW];
endmodule
